// File: rtl/core_pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/run-control unit: halt FSM states
// and the slot readiness rule used by the forwarding search.
package core_pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } run_state_t;

    // A slot k stages past READ can forward once its producer's latency has elapsed.
    function automatic logic slot_ready(input int k, input logic is_load,
                                        input int alu_lat, input int load_lat);
        return (k >= (is_load ? load_lat : alu_lat));
    endfunction

endpackage

// File: rtl/core_pipeline_hazard_ctrl_if.sv
// READ-stage, run-control and status signals of the hazard unit, bundled
// so the core and the hazard controller share one connection.
interface core_pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 3,
    parameter int FWD_W      = 2,
    parameter int CNT_W      = 16
);
    logic                  i_sys_stop;
    logic                  i_sys_start;
    logic                  i_rd_valid;
    logic [REG_ADDR_W-1:0] i_rd_src1;
    logic [REG_ADDR_W-1:0] i_rd_src2;
    logic                  i_rd_src1_used;
    logic                  i_rd_src2_used;
    logic [REG_ADDR_W-1:0] i_rd_dest;
    logic                  i_rd_writes;
    logic                  i_rd_is_load;
    logic                  i_ex_flush;
    logic                  o_issue;
    logic                  o_stall;
    logic                  o_flush_front;
    logic [FWD_W-1:0]      o_fwd_sel1;
    logic [FWD_W-1:0]      o_fwd_sel2;
    logic                  o_halted;
    logic [CNT_W-1:0]      o_stall_count;

    modport master (
        output i_sys_stop, i_sys_start, i_rd_valid, i_rd_src1, i_rd_src2,
               i_rd_src1_used, i_rd_src2_used, i_rd_dest, i_rd_writes,
               i_rd_is_load, i_ex_flush,
        input  o_issue, o_stall, o_flush_front, o_fwd_sel1, o_fwd_sel2,
               o_halted, o_stall_count
    );

    modport slave (
        input  i_sys_stop, i_sys_start, i_rd_valid, i_rd_src1, i_rd_src2,
               i_rd_src1_used, i_rd_src2_used, i_rd_dest, i_rd_writes,
               i_rd_is_load, i_ex_flush,
        output o_issue, o_stall, o_flush_front, o_fwd_sel1, o_fwd_sel2,
               o_halted, o_stall_count
    );

endinterface

// File: rtl/core_pipeline_hazard_ctrl_fwd_select.sv
// Youngest-match forwarding search for one READ operand: picks the slot to
// forward from, or flags a hazard when the youngest producer is not ready.
module core_pipeline_hazard_ctrl_fwd_select
    import core_pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_STAGES = 3,
    parameter int ALU_LAT    = 1,
    parameter int LOAD_LAT   = 2,
    parameter int FWD_W      = 2
) (
    input  logic [REG_ADDR_W-1:0]                 src,
    input  logic                                  used,
    input  logic [NUM_STAGES:1]                   slot_valid,
    input  logic [NUM_STAGES:1][REG_ADDR_W-1:0]   slot_dest,
    input  logic [NUM_STAGES:1]                   slot_is_load,
    output logic [FWD_W-1:0]                      fwd_sel,
    output logic                                  hazard
);

    // Scan oldest to youngest so the youngest match is the last one to assign.
    always_comb begin
        fwd_sel = '0;
        hazard  = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (used && slot_valid[k] && (slot_dest[k] == src)) begin
                if (slot_ready(k, slot_is_load[k], ALU_LAT, LOAD_LAT)) begin
                    fwd_sel = FWD_W'(k);
                    hazard  = 1'b0;
                end else begin
                    fwd_sel = '0;
                    hazard  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/core_pipeline_hazard_ctrl.sv
// Hazard and run-control unit: in-flight write scoreboard, per-operand
// forward/stall decision, stop/start halt FSM and a saturating stall counter.
module core_pipeline_hazard_ctrl
    import core_pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_STAGES = 3,
    parameter int ALU_LAT    = 1,
    parameter int LOAD_LAT   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    core_pipeline_hazard_ctrl_if.slave bus
);

    localparam int FWD_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES:1]                 slot_valid_q;
    logic [NUM_STAGES:1][REG_ADDR_W-1:0] slot_dest_q;
    logic [NUM_STAGES:1]                 slot_is_load_q;
    run_state_t                          state_q, state_d;
    logic [CNT_W-1:0]                    stall_cnt_q;
    logic                                hazard1, hazard2, hazard;
    logic                                running;

    core_pipeline_hazard_ctrl_fwd_select #(
        .REG_ADDR_W(REG_ADDR_W), .NUM_STAGES(NUM_STAGES),
        .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .FWD_W(FWD_W)
    ) u_sel1 (
        .src(bus.i_rd_src1), .used(bus.i_rd_valid & bus.i_rd_src1_used),
        .slot_valid(slot_valid_q), .slot_dest(slot_dest_q),
        .slot_is_load(slot_is_load_q), .fwd_sel(bus.o_fwd_sel1), .hazard(hazard1)
    );

    core_pipeline_hazard_ctrl_fwd_select #(
        .REG_ADDR_W(REG_ADDR_W), .NUM_STAGES(NUM_STAGES),
        .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .FWD_W(FWD_W)
    ) u_sel2 (
        .src(bus.i_rd_src2), .used(bus.i_rd_valid & bus.i_rd_src2_used),
        .slot_valid(slot_valid_q), .slot_dest(slot_dest_q),
        .slot_is_load(slot_is_load_q), .fwd_sel(bus.o_fwd_sel2), .hazard(hazard2)
    );

    assign hazard             = hazard1 | hazard2;
    assign running            = (state_q == ST_RUN);
    assign bus.o_stall        = hazard | (~running & bus.i_rd_valid);
    assign bus.o_issue        = bus.i_rd_valid & ~bus.o_stall & ~bus.i_ex_flush & running;
    assign bus.o_flush_front  = bus.i_ex_flush;
    assign bus.o_halted       = (state_q == ST_HALTED);
    assign bus.o_stall_count  = stall_cnt_q;

    // Flush leaves the slots alone: the instruction already in EXECUTE completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slot_valid_q   <= '0;
            slot_dest_q    <= '0;
            slot_is_load_q <= '0;
        end else begin
            slot_valid_q[1]   <= bus.o_issue & bus.i_rd_writes;
            slot_dest_q[1]    <= bus.i_rd_dest;
            slot_is_load_q[1] <= bus.i_rd_is_load;
            for (int k = 2; k <= NUM_STAGES; k++) begin
                slot_valid_q[k]   <= slot_valid_q[k-1];
                slot_dest_q[k]    <= slot_dest_q[k-1];
                slot_is_load_q[k] <= slot_is_load_q[k-1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_HALTED;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (running && hazard && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    // Stop beats start everywhere; a drain is abandoned only by a clean start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.i_sys_stop) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.i_sys_start && !bus.i_sys_stop) state_d = ST_RUN;
                else if (slot_valid_q == '0)            state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (bus.i_sys_start && !bus.i_sys_stop) state_d = ST_RUN;
            end
            default: state_d = ST_HALTED;
        endcase
    end

endmodule

// File: tb/tb_core_pipeline_hazard_ctrl.sv
// Scoreboard bench for core_pipeline_hazard_ctrl: directed vectors push
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_core_pipeline_hazard_ctrl;

    logic clk;
    logic rst;

    core_pipeline_hazard_ctrl_if #(.REG_ADDR_W(3), .FWD_W(2), .CNT_W(16)) bus ();

    core_pipeline_hazard_ctrl #(
        .REG_ADDR_W(3), .NUM_STAGES(3), .ALU_LAT(1), .LOAD_LAT(2), .CNT_W(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    typedef struct {
        string      name;
        logic       issue;
        logic       stall;
        logic       flush;
        logic [1:0] sel1;
        logic [1:0] sel2;
        logic       halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", name, field, actual, expected);
        end
    endtask

    // Drive one READ-stage vector just after the edge and queue its expected response.
    task automatic applyStimulus(
        input string name, input logic r, input logic stp, input logic sta,
        input logic v, input logic [2:0] s1, input logic [2:0] s2,
        input logic u1, input logic u2, input logic [2:0] d,
        input logic wr, input logic ld, input logic fl,
        input logic eIss, input logic eStl, input logic eFl,
        input logic [1:0] eS1, input logic [1:0] eS2,
        input logic eHalt, input logic [15:0] eCnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst                = r;
        bus.i_sys_stop     = stp;
        bus.i_sys_start    = sta;
        bus.i_rd_valid     = v;
        bus.i_rd_src1      = s1;
        bus.i_rd_src2      = s2;
        bus.i_rd_src1_used = u1;
        bus.i_rd_src2_used = u2;
        bus.i_rd_dest      = d;
        bus.i_rd_writes    = wr;
        bus.i_rd_is_load   = ld;
        bus.i_ex_flush     = fl;
        e.name   = name;
        e.issue  = eIss;
        e.stall  = eStl;
        e.flush  = eFl;
        e.sel1   = eS1;
        e.sel2   = eS2;
        e.halted = eHalt;
        e.cnt    = eCnt;
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput(e.name, "issue",  32'(bus.o_issue),       32'(e.issue));
            checkOutput(e.name, "stall",  32'(bus.o_stall),       32'(e.stall));
            checkOutput(e.name, "flush",  32'(bus.o_flush_front), 32'(e.flush));
            checkOutput(e.name, "sel1",   32'(bus.o_fwd_sel1),    32'(e.sel1));
            checkOutput(e.name, "sel2",   32'(bus.o_fwd_sel2),    32'(e.sel2));
            checkOutput(e.name, "halted", 32'(bus.o_halted),      32'(e.halted));
            checkOutput(e.name, "count",  32'(bus.o_stall_count), 32'(e.cnt));
        end
    end

    initial begin
        rst                = 1'b1;
        bus.i_sys_stop     = 1'b0;
        bus.i_sys_start    = 1'b0;
        bus.i_rd_valid     = 1'b0;
        bus.i_rd_src1      = '0;
        bus.i_rd_src2      = '0;
        bus.i_rd_src1_used = 1'b0;
        bus.i_rd_src2_used = 1'b0;
        bus.i_rd_dest      = '0;
        bus.i_rd_writes    = 1'b0;
        bus.i_rd_is_load   = 1'b0;
        bus.i_ex_flush     = 1'b0;

        //             name            rst stp sta  v s1 s2 u1 u2  d wr ld fl   iss stl fl s1 s2 h cnt
        applyStimulus("reset",          1, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
        applyStimulus("rst_state",      0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
        applyStimulus("start",          0, 0, 1,   0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
        applyStimulus("add_r3",         0, 0, 0,   1, 0, 0, 0, 0,  3, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        applyStimulus("use_r3",         0, 0, 0,   1, 3, 0, 1, 0,  4, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
        applyStimulus("load_r2",        0, 0, 0,   1, 0, 0, 0, 0,  2, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0);
        applyStimulus("loaduse_stall",  0, 0, 0,   1, 2, 0, 1, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
        applyStimulus("loaduse_fwd",    0, 0, 0,   1, 2, 0, 1, 0,  0, 0, 0, 0,  1, 0, 0, 2, 0, 0, 1);
        applyStimulus("alu_r5",         0, 0, 0,   1, 0, 0, 0, 0,  5, 1, 0, 0,  1, 0, 0, 0, 0, 0, 1);
        applyStimulus("load_r5",        0, 0, 0,   1, 0, 0, 0, 0,  5, 1, 1, 0,  1, 0, 0, 0, 0, 0, 1);
        applyStimulus("prio_stall",     0, 0, 0,   1, 5, 5, 1, 1,  0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1);
        applyStimulus("prio_fwd",       0, 0, 0,   1, 5, 5, 1, 1,  0, 0, 0, 0,  1, 0, 0, 2, 2, 0, 2);
        applyStimulus("load_r6",        0, 0, 0,   1, 0, 0, 0, 0,  6, 1, 1, 0,  1, 0, 0, 0, 0, 0, 2);
        applyStimulus("flush_stall",    0, 0, 0,   1, 6, 0, 1, 0,  7, 1, 0, 1,  0, 1, 1, 0, 0, 0, 2);
        applyStimulus("after_flush",    0, 0, 0,   1, 7, 6, 1, 1,  0, 0, 0, 0,  1, 0, 0, 0, 2, 0, 3);
        applyStimulus("w_r1",           0, 0, 0,   1, 0, 0, 0, 0,  1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 3);
        applyStimulus("w_r2_stop",      0, 1, 0,   1, 0, 0, 0, 0,  2, 1, 0, 0,  1, 0, 0, 0, 0, 0, 3);
        applyStimulus("drain_stopstart",0, 1, 1,   1, 2, 0, 1, 0,  0, 0, 0, 0,  0, 1, 0, 1, 0, 0, 3);
        applyStimulus("drain1",         0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3);
        applyStimulus("drain2",         0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3);
        applyStimulus("drain3",         0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3);
        applyStimulus("halted_ss",      0, 1, 1,   0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 3);
        applyStimulus("halted_start",   0, 0, 1,   1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 3);
        applyStimulus("run_w_r4",       0, 0, 0,   1, 0, 0, 0, 0,  4, 1, 0, 0,  1, 0, 0, 0, 0, 0, 3);
        applyStimulus("use_r4",         0, 0, 0,   1, 4, 0, 1, 0,  0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 3);
        applyStimulus("reset_mid",      1, 0, 0,   1, 4, 0, 1, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 0);
        applyStimulus("post_reset",     0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_queue: %0d expectations left, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
